// File: rtl/ms_es_mul_sequencer_if.sv
// ms_es_mul_sequencer_if: job request and job result valid/ready channels of the multiplier sequencer
//   in_valid/in_ready/in_operands              : operand set, master -> sequencer
//   out_valid/out_ready                        : result handshake, sequencer -> master
//   out_result/out_cycles/out_timeout/out_zero : product and job status
interface ms_es_mul_sequencer_if #(
   parameter int DATA_WIDTH = 5,
   parameter int NUM_INPUTS = 2,
   parameter int OUT_WIDTH  = DATA_WIDTH*NUM_INPUTS,
   parameter int CNT_W      = 11
);
   logic                             in_valid;
   logic                             in_ready;
   logic [NUM_INPUTS*DATA_WIDTH-1:0] in_operands;
   logic                             out_valid;
   logic                             out_ready;
   logic [OUT_WIDTH-1:0]             out_result;
   logic [CNT_W-1:0]                 out_cycles;
   logic                             out_timeout;
   logic                             out_zero;
   modport master (
      output in_valid, in_operands, out_ready,
      input  in_ready, out_valid, out_result, out_cycles, out_timeout, out_zero
   );
   modport slave (
      input  in_valid, in_operands, out_ready,
      output in_ready, out_valid, out_result, out_cycles, out_timeout, out_zero
   );
endinterface

// File: rtl/ms_es_mul_sequencer.sv
// ms_es_mul_sequencer: job controller for the stochastic multiplier datapath (clear, run, drain, hold)
//   clk, rst     : clock, asynchronous active-low reset
//   io           : operand-in / result-out channels (slave side)
//   dp_operands  : operands held stable for the datapath
//   dp_clr/dp_en : datapath clear and enable
//   dp_done      : datapath done, dp_result : datapath accumulator count
//   busy         : high in every state except IDLE
module ms_es_mul_sequencer #(
   parameter int DATA_WIDTH   = 5,
   parameter int NUM_INPUTS   = 2,
   parameter int OUT_WIDTH    = DATA_WIDTH*NUM_INPUTS,
   parameter int MAX_CYCLES   = 1024,
   parameter int DRAIN_CYCLES = 1,
   parameter int CNT_W        = $clog2(MAX_CYCLES+1)
) (
   input  logic                             clk,
   input  logic                             rst,
   ms_es_mul_sequencer_if.slave             io,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0] dp_operands,
   output logic                             dp_clr,
   output logic                             dp_en,
   input  logic                             dp_done,
   input  logic [OUT_WIDTH-1:0]             dp_result,
   output logic                             busy
);
   localparam int DW = $clog2(DRAIN_CYCLES+1);
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, HOLD} state_t;
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic [DW-1:0]    dcnt;
   logic             accept, has_zero, run_done, run_limit, drain_last;
   assign cnt_inc    = cnt + CNT_W'(1);
   assign accept     = state == IDLE && io.in_valid && io.in_ready;
   // done is meaningless in the first RUN cycle (counter still 0) while the SNGs leave clear
   assign run_done   = dp_done && cnt != '0;
   assign run_limit  = cnt_inc == CNT_W'(MAX_CYCLES);
   assign drain_last = dcnt == DW'(DRAIN_CYCLES-1);
   always_comb begin
      has_zero = 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++)
         has_zero |= io.in_operands[i*DATA_WIDTH +: DATA_WIDTH] == '0;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = has_zero ? HOLD : CLEAR;
         CLEAR:   state_n = RUN;
         RUN:     if (run_done || run_limit) state_n = DRAIN;
         DRAIN:   if (drain_last) state_n = HOLD;
         HOLD:    if (io.out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // every output is a flop loaded from the next state, so no input reaches an output combinationally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         cnt            <= '0;
         dcnt           <= '0;
         dp_operands    <= '0;
         dp_clr         <= 1'b1;
         dp_en          <= 1'b0;
         busy           <= 1'b0;
         io.in_ready    <= 1'b0;
         io.out_valid   <= 1'b0;
         io.out_result  <= '0;
         io.out_cycles  <= '0;
         io.out_timeout <= 1'b0;
         io.out_zero    <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= state == RUN ? cnt_inc : '0;
         dcnt         <= state == DRAIN ? dcnt + DW'(1) : '0;
         dp_clr       <= state_n inside {IDLE, CLEAR};
         dp_en        <= state_n == RUN;
         busy         <= state_n != IDLE;
         io.in_ready  <= state_n == IDLE;
         io.out_valid <= state_n == HOLD;
         if (accept) begin
            dp_operands    <= io.in_operands;
            io.out_timeout <= 1'b0;
            io.out_zero    <= has_zero;
            if (has_zero) begin
               io.out_result <= '0;
               io.out_cycles <= '0;
            end
         end
         if (state == RUN && state_n == DRAIN) begin
            io.out_cycles  <= cnt_inc;
            io.out_timeout <= !run_done;
         end
         if (state == DRAIN && drain_last) io.out_result <= dp_result;
      end
   end
endmodule

// File: tb/tb_ms_es_mul_sequencer.sv
// tb_ms_es_mul_sequencer: directed vector and corner-case bench for the multiplier sequencer
module tb_ms_es_mul_sequencer;
   localparam int DW = 5, NI = 2, OW = DW*NI, MAXC = 16, CW = $clog2(MAXC+1);
   logic           clk = 1'b0, rst = 1'b0;
   logic [NI*DW-1:0] dp_operands;
   logic           dp_clr, dp_en, busy;
   logic           dp_done = 1'b0;
   logic [OW-1:0]  dp_result = '0;
   int             total = 0, passed = 0;
   int             run_k = 0, en_cnt = 0, done_at = 0, prod = 0;
   bit             done_first = 1'b0;
   ms_es_mul_sequencer_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .OUT_WIDTH(OW), .CNT_W(CW)) io();
   ms_es_mul_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .OUT_WIDTH(OW), .MAX_CYCLES(MAXC),
      .DRAIN_CYCLES(1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .io(io), .dp_operands(dp_operands), .dp_clr(dp_clr),
      .dp_en(dp_en), .dp_done(dp_done), .dp_result(dp_result), .busy(busy));
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end
   // datapath model: run_k is the 1-based index of the current RUN cycle
   always @(negedge clk) begin
      if (dp_clr) run_k = 0;
      else if (dp_en) run_k++;
      if (dp_en) en_cnt++;
      dp_done   = dp_en && ((done_at != 0 && run_k >= done_at) || (done_first && run_k == 1));
      dp_result = dp_clr ? '0 : OW'(prod);
   end
   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask
   task automatic start_job(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int n = 0;
      while (!io.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", n < 50, 1);
      io.in_operands = {b, a};
      io.in_valid    = 1'b1;
      prod           = int'(a) * int'(b);
      en_cnt         = 0;
      @(negedge clk);
      io.in_valid = 1'b0;
   endtask
   task automatic wait_out(output int lat);
      lat = 1;
      while (!io.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic finish_out;
      io.out_ready = 1'b1;
      @(negedge clk);
      io.out_ready = 1'b0;
   endtask
   typedef struct {
      logic [DW-1:0] a, b;
      int done_at, first, res, cyc, tmo, zro, lat, en;
   } vec_t;
   vec_t v[8];
   initial begin
      int lat;
      bit ok, seen;
      v[0] = '{5,  7,  14, 0, 35,  14, 0, 0, 17, 14};
      v[1] = '{3,  4,  0,  0, 12,  16, 1, 0, 19, 16};
      v[2] = '{0,  9,  0,  0, 0,   0,  0, 1, 1,  0};
      v[3] = '{3,  4,  16, 0, 12,  16, 0, 0, 19, 16};
      v[4] = '{2,  3,  6,  1, 6,   6,  0, 0, 9,  6};
      v[5] = '{31, 31, 2,  0, 961, 2,  0, 0, 5,  2};
      v[6] = '{7,  0,  5,  0, 0,   0,  0, 1, 1,  0};
      v[7] = '{1,  1,  1,  1, 1,   2,  0, 0, 5,  2};
      io.in_valid    = 1'b1;
      io.in_operands = '1;
      io.out_ready   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", io.in_ready, 0);
      chk("rst_dp_clr", dp_clr, 1);
      chk("rst_dp_en", dp_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", io.out_valid, 0);
      chk("rst_out_result", io.out_result, 0);
      chk("rst_out_cycles", io.out_cycles, 0);
      chk("rst_out_timeout", io.out_timeout, 0);
      chk("rst_out_zero", io.out_zero, 0);
      chk("rst_dp_operands", dp_operands, 0);
      rst         = 1'b1;
      io.in_valid = 1'b0;
      #1 chk("release_in_ready_low", io.in_ready, 0);
      @(posedge clk);
      #1 chk("release_in_ready_high", io.in_ready, 1);
      @(negedge clk);
      foreach (v[i]) begin
         done_at    = v[i].done_at;
         done_first = v[i].first[0];
         start_job(v[i].a, v[i].b);
         wait_out(lat);
         chk($sformatf("v%0d_latency", i), lat, v[i].lat);
         chk($sformatf("v%0d_result", i), io.out_result, v[i].res);
         chk($sformatf("v%0d_cycles", i), io.out_cycles, v[i].cyc);
         chk($sformatf("v%0d_timeout", i), io.out_timeout, v[i].tmo);
         chk($sformatf("v%0d_zero", i), io.out_zero, v[i].zro);
         chk($sformatf("v%0d_en_cycles", i), en_cnt, v[i].en);
         finish_out;
         chk($sformatf("v%0d_valid_drop", i), io.out_valid, 0);
      end
      done_at    = 14;
      done_first = 1'b0;
      start_job(5'd5, 5'd7);
      wait_out(lat);
      chk("bp_first_valid", io.out_valid, 1);
      io.in_operands = {5'd3, 5'd6};
      io.in_valid    = 1'b1;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         ok &= io.out_valid && !io.in_ready && io.out_result == 35 && dp_operands == {5'd7, 5'd5};
      end
      chk("bp_stall_hold", ok, 1);
      prod    = 18;
      done_at = 3;
      io.out_ready = 1'b1;
      @(negedge clk);
      io.out_ready = 1'b0;
      chk("bp_valid_drop", io.out_valid, 0);
      chk("bp_in_ready_after", io.in_ready, 1);
      @(negedge clk);
      io.in_valid = 1'b0;
      chk("bp_second_ops", dp_operands, {5'd3, 5'd6});
      chk("bp_second_busy", busy, 1);
      chk("bp_second_in_ready", io.in_ready, 0);
      wait_out(lat);
      chk("bp_second_result", io.out_result, 18);
      chk("bp_second_cycles", io.out_cycles, 3);
      finish_out;
      done_at = 0;
      start_job(5'd9, 5'd9);
      repeat (5) @(negedge clk);
      chk("abort_midrun_en", dp_en, 1);
      #2 rst = 1'b0;
      #1;
      chk("abort_dp_clr", dp_clr, 1);
      chk("abort_dp_en", dp_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", io.in_ready, 0);
      @(negedge clk);
      rst  = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= io.out_valid;
      end
      chk("abort_no_valid", seen, 0);
      chk("abort_idle_ready", io.in_ready, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
